// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush
// to a NOP value and a saturating stall counter. in_ready comes straight from a flop.
module pipe_stage_skid #(
  parameter int                 INSTR_W = 32,
  parameter int                 ADDR_W  = 10,
  parameter logic [INSTR_W-1:0] NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               m_valid_reg, m_valid_next;
  logic [INSTR_W-1:0] m_instr_reg, m_instr_next;
  logic [ADDR_W-1:0]  m_addr_reg,  m_addr_next;
  logic               s_valid_reg, s_valid_next;
  logic [INSTR_W-1:0] s_instr_reg, s_instr_next;
  logic [ADDR_W-1:0]  s_addr_reg,  s_addr_next;
  logic               in_ready_reg, in_ready_next;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = m_valid_reg & out_ready;

  always_comb begin
    m_valid_next   = m_valid_reg;
    m_instr_next   = m_instr_reg;
    m_addr_next    = m_addr_reg;
    s_valid_next   = s_valid_reg;
    s_instr_next   = s_instr_reg;
    s_addr_next    = s_addr_reg;
    stall_cnt_next = stall_cnt_reg;

    if (m_valid_reg && !out_ready && (stall_cnt_reg != CNT_MAX))
      stall_cnt_next = stall_cnt_reg + CNT_ONE;

    if (flush) begin
      m_valid_next = 1'b0;
      m_instr_next = NOP_VAL;
      m_addr_next  = '0;
      s_valid_next = 1'b0;
      s_instr_next = NOP_VAL;
      s_addr_next  = '0;
    end else if (!m_valid_reg) begin
      if (in_fire) begin
        m_valid_next = 1'b1;
        m_instr_next = in_instr;
        m_addr_next  = in_addr;
      end
    end else if (!s_valid_reg) begin
      if (out_fire && in_fire) begin
        m_instr_next = in_instr;
        m_addr_next  = in_addr;
      end else if (out_fire) begin
        m_valid_next = 1'b0;
        m_instr_next = NOP_VAL;
        m_addr_next  = '0;
      end else if (in_fire) begin
        s_valid_next = 1'b1;
        s_instr_next = in_instr;
        s_addr_next  = in_addr;
      end
    end else if (out_fire) begin
      // Both full: in_ready is low, so only the skid-to-main move can happen.
      m_instr_next = s_instr_reg;
      m_addr_next  = s_addr_reg;
      s_valid_next = 1'b0;
      s_instr_next = NOP_VAL;
      s_addr_next  = '0;
    end

    in_ready_next = !s_valid_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_reg   <= 1'b0;
      m_instr_reg   <= NOP_VAL;
      m_addr_reg    <= '0;
      s_valid_reg   <= 1'b0;
      s_instr_reg   <= NOP_VAL;
      s_addr_reg    <= '0;
      in_ready_reg  <= 1'b1;
      stall_cnt_reg <= '0;
    end else begin
      m_valid_reg   <= m_valid_next;
      m_instr_reg   <= m_instr_next;
      m_addr_reg    <= m_addr_next;
      s_valid_reg   <= s_valid_next;
      s_instr_reg   <= s_instr_next;
      s_addr_reg    <= s_addr_next;
      in_ready_reg  <= in_ready_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = m_valid_reg;
  assign out_instr = m_instr_reg;
  assign out_addr  = m_addr_reg;
  // Two-bit sum of the valid bits.
  assign occupancy = {m_valid_reg & s_valid_reg, m_valid_reg ^ s_valid_reg};
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random handshake.
module tb_pipe_stage_skid;

  localparam int          IW  = 32;
  localparam int          AW  = 10;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_instr = '0;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_stage_skid #(
    .INSTR_W(IW), .ADDR_W(AW), .NOP_VAL(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two words.
  typedef struct packed { logic [IW-1:0] instr; logic [AW-1:0] addr; } word_t;
  word_t       q[$];
  int unsigned m_stall = 0;

  always @(posedge clk or posedge reset) begin
    bit can_push;
    if (reset) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
      can_push = (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && can_push) q.push_back({in_instr, in_addr});
      end
    end
  end

  always @(negedge clk) begin
    word_t head;
    if (chk_en && !reset) begin
      head = (q.size() > 0) ? q[0] : {NOP, {AW{1'b0}}};
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("out_instr", 64'(out_instr), 64'(head.instr));
      check("out_addr",  64'(out_addr),  64'(head.addr));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (out_valid && out_ready)
        $display("xfer t=%0t instr=%08h addr=%03h occ=%0d", $time, out_instr, out_addr, occupancy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] ad);
    in_valid = v;
    in_instr = ins;
    in_addr  = ad;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_prev;
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'(NOP));
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_stall",     64'(stall_cnt), 64'd0);

    // Streaming
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h1000_0000 + 32'(k), AW'(k));
      step();
      check("stream_instr", 64'(out_instr), 64'(32'h1000_0000 + 32'(k)));
      check("stream_addr",  64'(out_addr),  64'(k));
      check("stream_occ",   64'(occupancy), 64'd1);
      check("stream_stall", 64'(stall_cnt), 64'd0);
    end
    drive(1'b0, '0, '0);
    step();
    check("stream_drain", 64'(out_valid), 64'd0);

    // Back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 10'h001);
    step();
    check("bp_a_instr", 64'(out_instr), 64'hAAAA_0001);
    drive(1'b1, 32'hBBBB_0002, 10'h002);
    step();
    check("bp_occ2", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b1, 32'hCCCC_0003, 10'h003);
    step();
    check("bp_hold_a", 64'(out_instr), 64'hAAAA_0001);
    check("bp_stall2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    #1;
    check("bp_ready_not_comb", 64'(in_ready), 64'd0);
    step();
    check("bp_out_b", 64'(out_instr), 64'hBBBB_0002);
    check("bp_refill_ready", 64'(in_ready), 64'd1);
    step();
    check("bp_out_c", 64'(out_instr), 64'hCCCC_0003);
    check("bp_out_c_addr", 64'(out_addr), 64'h003);
    drive(1'b0, '0, '0);
    step();
    check("bp_empty", 64'(occupancy), 64'd0);

    // Flush with skid full
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 10'h001);
    step();
    drive(1'b1, 32'hBBBB_0002, 10'h002);
    step();
    check("fl_pre_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'hDDDD_0004, 10'h004);
    step();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_instr", 64'(out_instr), 64'(NOP));
    check("fl_addr",  64'(out_addr),  64'd0);
    check("fl_occ",   64'(occupancy), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    check("fl_stall", 64'(stall_cnt), 64'd4);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    check("fl_no_d", 64'(out_valid), 64'd0);

    // Async reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 32'hEEEE_0005, 10'h005);
    step();
    drive(1'b1, 32'hFFFF_0006, 10'h006);
    step();
    check("ar_occ2", 64'(occupancy), 64'd2);
    check("ar_stall5", 64'(stall_cnt), 64'd5);
    drive(1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    check("ar_stall0", 64'(stall_cnt), 64'd0);
    check("ar_ready",  64'(in_ready),  64'd1);
    check("ar_valid",  64'(out_valid), 64'd0);
    check("ar_instr",  64'(out_instr), 64'(NOP));
    check("ar_occ0",   64'(occupancy), 64'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 10'h15A);
    step();
    check("ar_first_valid", 64'(out_valid), 64'd1);
    check("ar_first_instr", 64'(out_instr), 64'h1234_5678);
    drive(1'b0, '0, '0);
    step();

    // Saturation
    out_ready = 1'b0;
    drive(1'b1, 32'h5A5A_0007, 10'h007);
    step();
    drive(1'b0, '0, '0);
    repeat (20) step();
    check("sat_stall", 64'(stall_cnt), 64'(SAT));
    check("sat_hold", 64'(out_instr), 64'h5A5A_0007);
    out_ready = 1'b1;
    step();
    check("sat_drain", 64'(occupancy), 64'd0);

    // Random handshake; upstream holds a refused word until taken or flushed
    acc_prev = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!(in_valid && !acc_prev))
        drive(1'($urandom_range(0, 1)), IW'($urandom), AW'($urandom_range(0, 1023)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 2);
      acc_prev  = (q.size() < 2) || flush;
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (3) step();
    check("rand_drained", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
